// File: rtl/event_counter_n_if.sv
// Board-side bundle of the key-event counter: switches, buttons and the
// direction input, plus the LED, seven-segment and overflow outputs.
interface event_counter_n_if #(
    parameter int SW_W  = 10,
    parameter int CNT_W = 8
);
    localparam int DIGITS = CNT_W / 4;

    logic [SW_W-1:0]     sw_i;
    logic [1:0]          key_i;
    logic                dir_i;
    logic [SW_W-1:0]     ledr_o;
    logic [7*DIGITS-1:0] hex_o;
    logic                ovf_o;

    // Board / stimulus side: drives switches, keys and direction.
    modport master (
        output sw_i,
        output key_i,
        output dir_i,
        input  ledr_o,
        input  hex_o,
        input  ovf_o
    );

    // Counter side: consumes the inputs, produces the display outputs.
    modport slave (
        input  sw_i,
        input  key_i,
        input  dir_i,
        output ledr_o,
        output hex_o,
        output ovf_o
    );
endinterface

// File: rtl/event_counter_n.sv
// Parametrised key-event counter. KEY0 presses (debounced, active-low) step a
// CNT_W-bit up/down counter and capture the switch bank; KEY1 clears. The count
// is shown on CNT_W/4 active-low seven-segment digits. Fully synchronous.
module event_counter_n #(
    parameter int CNT_W        = 8,
    parameter int SW_W         = 10,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int WRAP_MODE    = 1
) (
    input  logic              clk100_i,
    input  logic              rstn_i,
    event_counter_n_if.slave  bus
);

    localparam int DIGITS = CNT_W / 4;
    localparam int DW     = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [DW-1:0]    DCNT_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [DW-1:0]    DCNT_ONE  = DW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } deb_state_e;

    // Active-low segment pattern for one hex nibble (bit0 = a .. bit6 = g).
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Per-key input conditioning state.
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [1:0]    vld_q, vld_d;      // sync2 holds a real pin sample (not reset fill)
    logic [1:0]    arm_q, arm_d;      // key seen released since reset
    logic [1:0]    deb_q, deb_d;      // debounced level, 1 = released
    logic [1:0]    press_q, press_d;  // one-cycle press event
    deb_state_e    state_q [2];
    deb_state_e    state_d [2];
    logic [DW-1:0] dcnt_q  [2];
    logic [DW-1:0] dcnt_d  [2];

    // Counter state.
    logic [CNT_W-1:0]    count_q, count_d;
    logic [SW_W-1:0]     ledr_q, ledr_d;
    logic                ovf_q, ovf_d;
    logic [7*DIGITS-1:0] hex_s;

    // Synchroniser, debouncer and press-edge detection for both keys.
    // A press is only reported once the key has been observed released after
    // reset, so a key held down through reset never produces an event.
    always_comb begin
        sync1_d = bus.key_i;
        sync2_d = sync1_q;
        vld_d   = {vld_q[0], 1'b1};
        for (int k = 0; k < 2; k++) begin
            state_d[k] = state_q[k];
            dcnt_d[k]  = dcnt_q[k];
            deb_d[k]   = deb_q[k];
            case (state_q[k])
                ST_STABLE: begin
                    if (sync2_q[k] != deb_q[k]) begin
                        state_d[k] = ST_CHANGING;
                        dcnt_d[k]  = DCNT_ONE;
                    end else begin
                        state_d[k] = ST_STABLE;
                        dcnt_d[k]  = '0;
                    end
                end
                ST_CHANGING: begin
                    if (sync2_q[k] == deb_q[k]) begin
                        state_d[k] = ST_STABLE;
                        dcnt_d[k]  = '0;
                    end else if (dcnt_q[k] == DCNT_LAST) begin
                        deb_d[k]   = sync2_q[k];
                        state_d[k] = ST_STABLE;
                        dcnt_d[k]  = '0;
                    end else begin
                        dcnt_d[k]  = dcnt_q[k] + DCNT_ONE;
                    end
                end
                default: begin
                    state_d[k] = ST_STABLE;
                    dcnt_d[k]  = '0;
                end
            endcase
            arm_d[k]   = arm_q[k] | (vld_q[1] & sync2_q[k]);
            press_d[k] = arm_q[k] & deb_q[k] & ~deb_d[k];
        end
    end

    // Count / capture / overflow update; a clear in the same cycle wins.
    always_comb begin
        count_d = count_q;
        ledr_d  = ledr_q;
        ovf_d   = ovf_q;
        if (press_q[1]) begin
            count_d = '0;
            ledr_d  = '0;
            ovf_d   = 1'b0;
        end else if (press_q[0]) begin
            ledr_d = bus.sw_i;
            if (!bus.dir_i) begin
                if (count_q == CNT_MAX) begin
                    ovf_d   = 1'b1;
                    count_d = (WRAP_MODE != 0) ? '0 : count_q;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end else begin
                if (count_q == '0) begin
                    ovf_d   = 1'b1;
                    count_d = (WRAP_MODE != 0) ? CNT_MAX : count_q;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // Seven-segment decode, combinational so the display tracks the count.
    always_comb begin
        hex_s = '0;
        for (int k = 0; k < DIGITS; k++) begin
            hex_s[7*k +: 7] = seg7(count_q[4*k +: 4]);
        end
    end

    // All state flops with synchronous active-low reset.
    always_ff @(posedge clk100_i) begin
        if (!rstn_i) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            vld_q   <= 2'b00;
            arm_q   <= 2'b00;
            deb_q   <= 2'b11;
            press_q <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= ST_STABLE;
                dcnt_q[k]  <= '0;
            end
            count_q <= '0;
            ledr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            vld_q   <= vld_d;
            arm_q   <= arm_d;
            deb_q   <= deb_d;
            press_q <= press_d;
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= state_d[k];
                dcnt_q[k]  <= dcnt_d[k];
            end
            count_q <= count_d;
            ledr_q  <= ledr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.ledr_o = ledr_q;
    assign bus.hex_o  = hex_s;
    assign bus.ovf_o  = ovf_q;

endmodule

// File: tb/tb_event_counter_n.sv
// Scoreboard bench for event_counter_n: one wrapping and one saturating
// instance share the same stimulus; the reference model predicts both.
module tb_event_counter_n;

    localparam int CNT_W = 8;
    localparam int SW_W  = 10;
    localparam int DCYC  = 4;
    localparam int LAT   = DCYC + 3;

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110 };

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    event_counter_n_if #(.SW_W(SW_W), .CNT_W(CNT_W)) if_w ();
    event_counter_n_if #(.SW_W(SW_W), .CNT_W(CNT_W)) if_s ();

    assign if_s.sw_i  = if_w.sw_i;
    assign if_s.key_i = if_w.key_i;
    assign if_s.dir_i = if_w.dir_i;

    event_counter_n #(.CNT_W(CNT_W), .SW_W(SW_W), .DEBOUNCE_CYC(DCYC), .WRAP_MODE(1)) dut_w (
        .clk100_i (clk),
        .rstn_i   (rstn),
        .bus      (if_w.slave)
    );

    event_counter_n #(.CNT_W(CNT_W), .SW_W(SW_W), .DEBOUNCE_CYC(DCYC), .WRAP_MODE(0)) dut_s (
        .clk100_i (clk),
        .rstn_i   (rstn),
        .bus      (if_s.slave)
    );

    typedef struct {
        int              due;
        bit              pre;
        int              cw;
        int              cs;
        logic [SW_W-1:0] led;
        bit              ow;
        bit              os;
        string           tag;
    } exp_t;

    exp_t sb [$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   end_req = 1'b0;

    // Reference model state (integer view of both counter variants).
    int              mw, ms;
    logic [SW_W-1:0] mled;
    bit              mow, mos;

    function automatic logic [13:0] hex_of(input int c);
        logic [7:0] b;
        b = 8'(c);
        return {SEG[b[7:4]], SEG[b[3:0]]};
    endfunction

    task automatic check(input exp_t e, input string what);
        logic [13:0] hw, hs;
        hw = hex_of(e.cw);
        hs = hex_of(e.cs);
        n_cmp++;
        if (if_w.hex_o !== hw || if_w.ledr_o !== e.led || if_w.ovf_o !== e.ow ||
            if_s.hex_o !== hs || if_s.ledr_o !== e.led || if_s.ovf_o !== e.os) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got wrap(hex=%b led=%h ovf=%b) sat(hex=%b led=%h ovf=%b) expected wrap(hex=%b led=%h ovf=%b) sat(hex=%b led=%h ovf=%b)",
                     what, cyc, if_w.hex_o, if_w.ledr_o, if_w.ovf_o,
                     if_s.hex_o, if_s.ledr_o, if_s.ovf_o,
                     hw, e.led, e.ow, hs, e.led, e.os);
        end
    endtask

    task automatic push(input int due, input bit pre, input string tag);
        exp_t e;
        e.due = due; e.pre = pre; e.cw = mw; e.cs = ms;
        e.led = mled; e.ow = mow; e.os = mos; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic model_clear();
        mw = 0; ms = 0; mled = '0; mow = 1'b0; mos = 1'b0;
    endtask

    task automatic model_count(input bit dn, input logic [SW_W-1:0] sw);
        mled = sw;
        if (!dn) begin
            if (mw == 255) begin mw = 0; mow = 1'b1; end else mw = mw + 1;
            if (ms == 255) mos = 1'b1; else ms = ms + 1;
        end else begin
            if (mw == 0) begin mw = 255; mow = 1'b1; end else mw = mw - 1;
            if (ms == 0) mos = 1'b1; else ms = ms - 1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        model_clear();
        push(cyc + 2, 1'b0, tag);
        tick(2);
        rstn = 1'b1;
        tick(3);
    endtask

    // keys: bit0 = count key, bit1 = clear key (1 = pressed). hold 0 = random.
    task automatic press(input logic [1:0] keys, input bit dn, input logic [SW_W-1:0] sw,
                         input int hold, input string tag);
        int h;
        if_w.dir_i = dn;
        if_w.sw_i  = sw;
        if_w.key_i = ~keys;
        if (keys[1]) model_clear();
        else if (keys[0]) model_count(dn, sw);
        push(cyc + LAT, 1'b1, tag);
        h = (hold > 0) ? hold : 5 + int'($urandom_range(0, 6));
        tick(h);
        if_w.key_i = 2'b11;
        tick(8 + int'($urandom_range(0, 4)));
    endtask

    // Monitor: compares outputs when a scoreboard entry falls due, and the
    // cycle before it to confirm the update does not arrive early.
    initial begin
        exp_t prev, e;
        bit   have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                if (sb[0].pre && have_prev && sb[0].due == cyc + 1)
                    check(prev, {sb[0].tag, "_early"});
                if (sb[0].due == cyc) begin
                    prev = sb.pop_front();
                    have_prev = 1'b1;
                    check(prev, prev.tag);
                end else if (sb[0].due < cyc) begin
                    e = sb.pop_front();
                    n_cmp++;
                    n_err++;
                    $display("FAIL %s: check at cyc %0d missed, now %0d", e.tag, e.due, cyc);
                end
            end
            if (end_req) begin
                while (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_cmp++;
                    n_err++;
                    $display("FAIL %s: never checked (due %0d, now %0d)", e.tag, e.due, cyc);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        if_w.key_i = 2'b11;
        if_w.dir_i = 1'b0;
        if_w.sw_i  = '0;
        rstn       = 1'b0;
        model_clear();
        @(negedge clk);

        // Reset state.
        do_reset("t1_reset");

        // Single press, long hold: one increment, switches captured.
        press(2'b01, 1'b0, 10'h2A5, 20, "t2_press");

        // Short glitches are ignored.
        for (int g = 0; g < 3; g++) begin
            if_w.key_i[0] = 1'b0;
            tick(3);
            if_w.key_i[0] = 1'b1;
            tick(6);
        end
        tick(4);
        push(cyc + 1, 1'b0, "t3_glitch");

        // Full wrap / saturate sweep.
        press(2'b10, 1'b0, 10'(($urandom)), 0, "t4_clear");
        for (int i = 0; i < 256; i++)
            press(2'b01, 1'b0, 10'(($urandom)), 0, "t4_up");
        press(2'b01, 1'b1, 10'(($urandom)), 0, "t4_down_wrap");
        press(2'b10, 1'b0, 10'(($urandom)), 0, "t4_clear2");
        press(2'b01, 1'b1, 10'(($urandom)), 0, "t4_down_at0");

        // Random mix of count/clear presses.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0)
                press(2'b10, 1'b0, 10'(($urandom)), 0, "rnd_clear");
            else
                press(2'b01, 1'($urandom_range(0, 1)), 10'(($urandom)), 0, "rnd_count");
        end

        // Both keys together: clear wins, then a normal press counts to 1.
        press(2'b11, 1'b0, 10'h3FF, 0, "t5_both");
        press(2'b01, 1'b0, 10'h155, 0, "t5_after");

        // Reset during a debounce with the key held: no event afterwards.
        if_w.sw_i     = 10'h0F0;
        if_w.key_i[0] = 1'b0;
        tick(3);
        do_reset("t6_reset");
        tick(15);
        if_w.key_i[0] = 1'b1;
        tick(12);
        push(cyc + 1, 1'b0, "t6_noevent");
        press(2'b01, 1'b0, 10'h0C3, 0, "t6_press");

        for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
        end_req = 1'b1;
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
